// File: rtl/seq_sm_divider_if.sv
// seq_sm_divider_if: start/busy/done handshake and operand/result bus of the divider
interface seq_sm_divider_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] numerator;
  logic [WIDTH-1:0] denominator;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic divbyzero;
  modport master (output start, numerator, denominator, input busy, done, quotient, remainder, divbyzero);
  modport slave (input start, numerator, denominator, output busy, done, quotient, remainder, divbyzero);
endinterface

// File: rtl/seq_sm_divider.sv
// seq_sm_divider: multi-cycle restoring sign-magnitude divider with start/busy/done handshake
module seq_sm_divider #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  seq_sm_divider_if.slave bus
);
  localparam int M = WIDTH - 1;
  localparam int CW = $clog2(M) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0] num_q, num_d, den_q, den_d;
  logic [M:0] rem_q, rem_d, rem_sh, diff;
  logic sn_q, sn_d, sq_q, sq_d, dz_q, dz_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic accept, finish, step;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      sn_q <= 1'b0;
      sq_q <= 1'b0;
      dz_q <= 1'b0;
      dbz_q <= 1'b0;
      quo_q <= '0;
      rmd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      den_q <= den_d;
      rem_q <= rem_d;
      sn_q <= sn_d;
      sq_q <= sq_d;
      dz_q <= dz_d;
      dbz_q <= dbz_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
    end
  end
  // The counter runs M-1 down to all-ones; the all-ones cycle writes the results.
  // A zero divisor skips the steps and finishes on the first CALC cycle.
  always_comb begin
    accept = bus.start && state_q != CALC;
    finish = state_q == CALC && (dz_q || cnt_q == '1);
    step = state_q == CALC && !finish;
    rem_sh = {rem_q[M-1:0], num_q[M-1]};
    diff = rem_sh - {1'b0, den_q};
    state_d = accept ? CALC : finish ? DONE : state_q == CALC ? CALC : IDLE;
    cnt_d = accept ? CW'(M - 1) : step ? cnt_q - 1'b1 : cnt_q;
    num_d = accept ? bus.numerator[M-1:0] : step ? {num_q[M-2:0], ~diff[M]} : num_q;
    rem_d = accept ? '0 : step ? (diff[M] ? rem_sh : diff) : rem_q;
    den_d = accept ? bus.denominator[M-1:0] : den_q;
    sn_d = accept ? bus.numerator[M] : sn_q;
    sq_d = accept ? bus.numerator[M] ^ bus.denominator[M] : sq_q;
    dz_d = accept ? bus.denominator[M-1:0] == '0 : dz_q;
    quo_d = finish ? (dz_q ? '0 : {sq_q && |num_q, num_q}) : quo_q;
    rmd_d = finish ? (dz_q ? '0 : {sn_q && |rem_q[M-1:0], rem_q[M-1:0]}) : rmd_q;
    dbz_d = finish ? dz_q : dbz_q;
  end
  always_comb begin
    bus.busy = state_q == CALC;
    bus.done = state_q == DONE;
    bus.quotient = quo_q;
    bus.remainder = rmd_q;
    bus.divbyzero = dbz_q;
  end
endmodule
